// File: rtl/fd_scan_sequencer_if.sv
// fd_scan_sequencer_if: the sequencer's links to the pixel memory, the register file
// and the FAST9 comparison datapath.
interface fd_scan_sequencer_if;
  localparam int unsigned AW = 15;
  localparam int unsigned NW = 5;

  logic          start;
  logic          dpReady;
  logic          pretestReject;
  logic [AW-1:0] refAddr;
  logic [NW-1:0] adjNumber;
  logic          memRe;
  logic [NW-1:0] regAddr;
  logic          regWe;
  logic          readen;
  logic          busy;
  logic          frameDone;

  modport master (
    input  start, dpReady, pretestReject,
    output refAddr, adjNumber, memRe, regAddr, regWe, readen, busy, frameDone
  );

  modport slave (
    output start, dpReady, pretestReject,
    input  refAddr, adjNumber, memRe, regAddr, regWe, readen, busy, frameDone
  );
endinterface

// File: rtl/fd_scan_sequencer.sv
// fd_scan_sequencer: raster-scan read sequencer for the FAST9 corner datapath.
// Define FAST_PRETEST_EN to enable the compass-point pretest (PRECHK state).
module fd_scan_sequencer #(
  parameter int unsigned IMG_W  = 176,
  parameter int unsigned IMG_H  = 120,
  parameter int unsigned BORDER = 3,
  parameter int unsigned RD_LAT = 2
) (
  input logic                 clock,
  input logic                 nReset,
  fd_scan_sequencer_if.master bus
);
  localparam int unsigned AW         = 15;
  localparam int unsigned NW         = 5;
  localparam int unsigned IW         = 4;
  localparam int unsigned DCW        = 2;
  localparam int unsigned XW         = $clog2(IMG_W);
  localparam int unsigned YW         = $clog2(IMG_H);
  localparam int unsigned X_LAST     = IMG_W - 1 - BORDER;
  localparam int unsigned Y_LAST     = IMG_H - 1 - BORDER;
  localparam int unsigned START_ADDR = BORDER * IMG_W + BORDER;
  localparam int unsigned WRAP_STEP  = 2 * BORDER + 1;
  localparam int unsigned LAST_IDX   = 15;
`ifdef FAST_PRETEST_EN
  localparam int unsigned PRE_IDX    = 3;
  localparam int unsigned RESUME_IDX = 4;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HANDOFF,
    ADVANCE
`ifdef FAST_PRETEST_EN
    , PRECHK
`endif
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [IW-1:0] issueIdx;
  logic [DCW-1:0] drainCnt;
  logic [AW-1:0] refAddr;
  logic [NW-1:0] adjNumber;
  logic          memRe;
  logic          readen;
  logic          busy;
  logic          frameDone;
  logic          wePipe   [RD_LAT];
  logic [NW-1:0] addrPipe [RD_LAT];
  logic          issueLast;

  // Circle-point index for the k-th read of a candidate.
  function automatic logic [IW-1:0] issueOrder(input logic [IW-1:0] k);
`ifdef FAST_PRETEST_EN
    // Compass points first so the pretest can run on the first four returns.
    case (k)
      4'd0:    return 4'd0;
      4'd1:    return 4'd4;
      4'd2:    return 4'd8;
      4'd3:    return 4'd12;
      4'd4:    return 4'd1;
      4'd5:    return 4'd2;
      4'd6:    return 4'd3;
      4'd7:    return 4'd5;
      4'd8:    return 4'd6;
      4'd9:    return 4'd7;
      4'd10:   return 4'd9;
      4'd11:   return 4'd10;
      4'd12:   return 4'd11;
      4'd13:   return 4'd13;
      4'd14:   return 4'd14;
      default: return 4'd15;
    endcase
`else
    return k;
`endif
  endfunction

`ifndef FAST_PRETEST_EN
  logic unusedPretest;
  assign unusedPretest = bus.pretestReject;
`endif

  // Last read of the current burst: end of circle, or end of compass points.
  always_comb begin
    issueLast = (issueIdx == IW'(LAST_IDX));
`ifdef FAST_PRETEST_EN
    if (issueIdx == IW'(PRE_IDX)) issueLast = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      issueIdx  <= '0;
      drainCnt  <= '0;
      refAddr   <= '0;
      adjNumber <= '0;
      memRe     <= 1'b0;
      readen    <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        wePipe[i]   <= 1'b0;
        addrPipe[i] <= '0;
      end
    end else begin
      frameDone <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            x         <= XW'(BORDER);
            y         <= YW'(BORDER);
            refAddr   <= AW'(START_ADDR);
            memRe     <= 1'b1;
            issueIdx  <= '0;
            adjNumber <= NW'(issueOrder(IW'(0)));
          end
        end

        ISSUE: begin
          if (issueLast) begin
            state    <= DRAIN;
            memRe    <= 1'b0;
            drainCnt <= '0;
          end else begin
            issueIdx  <= issueIdx + IW'(1);
            adjNumber <= NW'(issueOrder(issueIdx + IW'(1)));
          end
        end

        // Wait out the read latency so every return lands before the handoff.
        DRAIN: begin
          if (drainCnt == DCW'(RD_LAT - 1)) begin
`ifdef FAST_PRETEST_EN
            if (issueIdx == IW'(PRE_IDX)) begin
              state <= PRECHK;
            end else begin
              state  <= HANDOFF;
              readen <= 1'b1;
            end
`else
            state  <= HANDOFF;
            readen <= 1'b1;
`endif
          end else begin
            drainCnt <= drainCnt + DCW'(1);
          end
        end

`ifdef FAST_PRETEST_EN
        PRECHK: begin
          if (bus.pretestReject) begin
            state <= ADVANCE;
          end else begin
            state     <= ISSUE;
            memRe     <= 1'b1;
            issueIdx  <= IW'(RESUME_IDX);
            adjNumber <= NW'(issueOrder(IW'(RESUME_IDX)));
          end
        end
`endif

        HANDOFF: begin
          if (bus.dpReady) begin
            state  <= ADVANCE;
            readen <= 1'b0;
          end
        end

        // Step the raster position; the last candidate keeps its address.
        ADVANCE: begin
          if (x == XW'(X_LAST) && y == YW'(Y_LAST)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frameDone <= 1'b1;
          end else begin
            if (x < XW'(X_LAST)) begin
              x       <= x + XW'(1);
              refAddr <= refAddr + AW'(1);
            end else begin
              x       <= XW'(BORDER);
              y       <= y + YW'(1);
              refAddr <= refAddr + AW'(WRAP_STEP);
            end
            state     <= ISSUE;
            memRe     <= 1'b1;
            issueIdx  <= '0;
            adjNumber <= NW'(issueOrder(IW'(0)));
          end
        end

        default: state <= IDLE;
      endcase

      // Read-return delay line feeding the register-file write port.
      wePipe[0]   <= memRe;
      addrPipe[0] <= adjNumber;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        wePipe[i]   <= wePipe[i-1];
        addrPipe[i] <= addrPipe[i-1];
      end
    end
  end

  assign bus.refAddr   = refAddr;
  assign bus.adjNumber = adjNumber;
  assign bus.memRe     = memRe;
  assign bus.regAddr   = addrPipe[RD_LAT-1];
  assign bus.regWe     = wePipe[RD_LAT-1];
  assign bus.readen    = readen;
  assign bus.busy      = busy;
  assign bus.frameDone = frameDone;
endmodule

// File: doc/fd_scan_sequencer.md
# fd_scan_sequencer

Raster-scan sequencer for the FAST9 corner-detection datapath. On a `start` pulse it walks every candidate pixel of the frame, skipping the 3-pixel border. For each pixel it issues the 16 Bresenham-circle reads to the pixel memory and steers the returning data into the datapath register file. It then hands the candidate to the comparison datapath with a ready/valid handshake and ends the frame with a `frameDone` pulse.

## Interface
- `IMG_W`, 176, image width in pixels.
- `IMG_H`, 120, image height in pixels.
- `BORDER`, 3, margin skipped on every side (circle radius).
- `RD_LAT`, 2, pixel-memory read latency in cycles (legal 1..3).
- `clock` input 1: rising-edge clock.
- `nReset` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle frame start request, honoured only in IDLE.
- `dpReady` input 1: datapath can accept a candidate.
- `pretestReject` input 1: datapath verdict from the compass-point pretest. Used only with `FAST_PRETEST_EN`.
- `refAddr` output 15: linear address of the current candidate, y*IMG_W+x.
- `adjNumber` output 5: circle-point index (0..15) of the read issued this cycle.
- `memRe` output 1: pixel-memory read strobe, qualifies `adjNumber`.
- `regAddr` output 5: register-file slot for returning data, equal to `adjNumber` delayed RD_LAT cycles.
- `regWe` output 1: register-file write strobe, equal to `memRe` delayed RD_LAT cycles.
- `readen` output 1: candidate valid to the datapath.
- `busy` output 1: high from the cycle after an accepted `start` until `frameDone`.
- `frameDone` output 1: one-cycle pulse after the last candidate is handed off.

## Operation
- **States:** IDLE, ISSUE, DRAIN, HANDOFF, ADVANCE, plus PRECHK when `FAST_PRETEST_EN` is defined.
- **IDLE → ISSUE:** taken on `start`. The same edge loads x=y=BORDER and `refAddr`=BORDER*IMG_W+BORDER (531 with defaults).
- **ISSUE:** one read per cycle, `memRe`=1, `adjNumber` stepping through the issue order. After the last read the block goes to DRAIN.
- **DRAIN:** lasts RD_LAT cycles with `memRe`=0 while the pipeline finishes `regWe` writes, then goes to HANDOFF.
- **HANDOFF:** `readen`=1, held until `dpReady`=1 on a rising edge. That edge is the transfer, and the next state is ADVANCE.
- **ADVANCE (1 cycle):**
  - If x < IMG_W-1-BORDER: x+1 and `refAddr`+1.
  - Otherwise: x=BORDER, y+1, `refAddr`+2*BORDER+1.
  - If the candidate was the last one (x=IMG_W-1-BORDER and y=IMG_H-1-BORDER): pulse `frameDone`, drop `busy`, go to IDLE.
  - Otherwise go to ISSUE.
- **Address width:** the address is computed incrementally, with no multiplier. `refAddr` stays within 15 bits for all legal parameters (IMG_W*IMG_H ≤ 32768).
- **Frame size:** (IMG_W-2*BORDER)*(IMG_H-2*BORDER) candidates. With defaults this is 19380, ending at `refAddr`=20588.
- **`start` while busy:** ignored.
- **Reset mid-frame:** immediately returns to IDLE and flushes the `regWe` delay line, so no stale write occurs after reset is released.

## Timing
- **Reset values:** `refAddr`=0, `adjNumber`=0, `regAddr`=0, `memRe`=0, `regWe`=0, `readen`=0, `busy`=0, `frameDone`=0.
- **Output timing:** all outputs are registered.
- **Read return:** the read issued in cycle t produces `regWe` with the same index in `regAddr` in cycle t+RD_LAT.
- **Per-candidate cost** (`dpReady` held high, no pretest): 16 ISSUE + RD_LAT DRAIN + 1 HANDOFF + 1 ADVANCE cycles, i.e. 20 with defaults.
- **Start latency:** `busy` rises and the first `memRe` occurs on the cycle after `start` is sampled.
- **HANDOFF:** `readen` stays high with `refAddr` stable for every cycle `dpReady`=0. The register file is not written during HANDOFF.

## Configuration
- **Macro:** `FAST_PRETEST_EN`.
- **Defined:**
  - Issue order is 0,4,8,12,1,2,3,5,6,7,9,10,11,13,14,15.
  - After the 4th read the block spends RD_LAT drain cycles, then 1 PRECHK cycle that samples `pretestReject`.
  - `pretestReject`=1: the remaining 12 reads and HANDOFF are skipped and the next state is ADVANCE, with no `readen` for that candidate. A rejected candidate therefore takes 4+RD_LAT+1+1 cycles (8 with defaults).
  - `pretestReject`=0: the remaining 12 reads resume in ISSUE.
- **Undefined:**
  - Issue order is 0..15 sequential, with no PRECHK state.
  - `pretestReject` is still present as a port but is ignored.

## Test plan
- **Reset:** assert `nReset`=0 mid-ISSUE → all outputs 0 on the same cycle. After release, no `regWe` appears, the block is in IDLE, and `busy`=0.
- **First candidate:** `start` pulse with `dpReady`=1, defaults → `refAddr`=531. `adjNumber` runs 0..15 over 16 cycles, `regWe` with `regAddr` 0..15 lags it by 2 cycles, `readen` is high 1 cycle, and the next `refAddr`=532 is 20 cycles after the first `memRe`.
- **Row wrap:** candidate at x=172, y=3 (`refAddr`=700) → next `refAddr`=707 (x=3, y=4).
- **Backpressure:** `dpReady`=0 for 5 cycles during HANDOFF → `readen` is held for 6 cycles, `refAddr` is stable, and there is no `memRe` or `regWe`. The transfer happens on the cycle `dpReady`=1.
- **Full frame:** defaults with `dpReady`=1 → 19380 `readen` transfers, the last at `refAddr`=20588, then `frameDone` for 1 cycle, `busy`=0, and a `start` during the frame is ignored.
- **Pretest (macro defined):** `pretestReject`=1 on the first candidate → only `adjNumber` 0,4,8,12 are issued, there is no `readen`, and the next `refAddr`=532 is 8 cycles after the first `memRe`. With `pretestReject`=0 all 16 reads are issued in the stated order.
